// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - DM-priority arbiter sharing one single-port memory between IF and DM
// Optional perf counters are compiled in when MEM_ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
  parameter int ADDR_W        = 64,
  parameter int DATA_W        = 64,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef MEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_conflict_cycles
`endif
);

  localparam int SW = (MAX_DM_STREAK < 1) ? 1 : $clog2(MAX_DM_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic              win_dm_q, win_dm_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_dm, grant_if;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      win_dm_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      win_dm_q    <= win_dm_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    win_dm_d    = win_dm_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    grant_dm    = 1'b0;
    grant_if    = 1'b0;

    case (state_q)
      IDLE: begin
        // DM wins unless IF has already been passed over MAX_DM_STREAK times in a row.
        grant_dm = dm_req && (!if_req || (streak_q != STREAK_MAX));
        grant_if = if_req && !grant_dm;

        if (!if_req || grant_if) begin
          streak_d = '0;
        end else if (grant_dm) begin
          streak_d = streak_q + SW'(1);
        end

        if (grant_dm) begin
          win_dm_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = BUSY;
        end else if (grant_if) begin
          win_dm_d   = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          state_d    = BUSY;
        end
      end

      BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (win_dm_q) begin
            dm_ack_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end

      // One dead cycle so a requester still holding req after its ack is not re-served.
      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_stall  = dm_req & ~dm_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_q, perf_if_d;
  logic [31:0] perf_dm_q, perf_dm_d;
  logic [31:0] perf_conf_q, perf_conf_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_if_q   <= '0;
      perf_dm_q   <= '0;
      perf_conf_q <= '0;
    end else begin
      perf_if_q   <= perf_if_d;
      perf_dm_q   <= perf_dm_d;
      perf_conf_q <= perf_conf_d;
    end
  end

  // Saturating counters: they stick at all-ones rather than wrapping.
  always_comb begin
    perf_if_d   = perf_if_q;
    perf_dm_d   = perf_dm_q;
    perf_conf_d = perf_conf_q;
    if (grant_if && (perf_if_q != 32'hFFFF_FFFF)) begin
      perf_if_d = perf_if_q + 32'd1;
    end
    if (grant_dm && (perf_dm_q != 32'hFFFF_FFFF)) begin
      perf_dm_d = perf_dm_q + 32'd1;
    end
    if (if_req && dm_req && (perf_conf_q != 32'hFFFF_FFFF)) begin
      perf_conf_d = perf_conf_q + 32'd1;
    end
  end

  assign perf_if_grants       = perf_if_q;
  assign perf_dm_grants       = perf_dm_q;
  assign perf_conflict_cycles = perf_conf_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level model: memory contents, DM-priority grant order with streak limit.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [63:0] if_rdata;
  logic        if_stall;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        dm_stall;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
`ifdef MEM_ARB_PERF_CNT_EN
  logic [31:0] perf_if_grants;
  logic [31:0] perf_dm_grants;
  logic [31:0] perf_conflict_cycles;
`endif

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants),
    .perf_conflict_cycles(perf_conflict_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] mem_model [logic [63:0]];
  logic [63:0] exp_if_rdata, exp_dm_rdata;
  int streak_m, n_if_gr, n_dm_gr, n_conf;
  bit order_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mval(input logic [63:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 64'hC0FF_EE00_1234_5678;
  endfunction

  function automatic logic [63:0] rnd_addr();
    return 64'($urandom_range(0, 15)) << 3;
  endfunction

  task automatic tick();
    if (if_req && dm_req) n_conf++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    streak_m = 0;
    n_if_gr = 0;
    n_dm_gr = 0;
    n_conf = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_if_ack"}, if_ack, 0);
    chk({pfx, "_if_rdata"}, if_rdata, 0);
    chk({pfx, "_if_stall"}, if_stall, 0);
    chk({pfx, "_dm_ack"}, dm_ack, 0);
    chk({pfx, "_dm_rdata"}, dm_rdata, 0);
    chk({pfx, "_dm_stall"}, dm_stall, 0);
    chk({pfx, "_mem_req"}, mem_req, 0);
    chk({pfx, "_mem_we"}, mem_we, 0);
    chk({pfx, "_mem_addr"}, mem_addr, 0);
    chk({pfx, "_mem_wdata"}, mem_wdata, 0);
`ifdef MEM_ARB_PERF_CNT_EN
    chk({pfx, "_perf_if"}, perf_if_grants, 0);
    chk({pfx, "_perf_dm"}, perf_dm_grants, 0);
    chk({pfx, "_perf_conf"}, perf_conflict_cycles, 0);
`endif
  endtask

  // One round: IF fetch (optional) plus n_dm back-to-back DM requests; DM is re-raised on each ack.
  task automatic run_round(input int n_dm, input bit do_if, input logic [63:0] ia,
                           input bit dwe, input logic [63:0] da, input logic [63:0] dwd,
                           input int lat, output int first_ack, output int last_ack);
    int dm_left, cyc, busy_cnt, cur_lat;
    bit if_left, grant_due, in_busy, exp_a, win_dm, g_we;
    logic [63:0] g_addr, g_wdata, rd_val;
    first_ack = -1; last_ack = -1;
    dm_left = n_dm; if_left = do_if; cyc = 0; busy_cnt = 0; cur_lat = 1;
    in_busy = 0; exp_a = 0; win_dm = 0; g_we = 0;
    g_addr = '0; g_wdata = '0; rd_val = '0;
    if_req = do_if; if_addr = ia;
    dm_req = (n_dm > 0); dm_we = dwe; dm_addr = da; dm_wdata = dwd;
    mem_ready = 1'b0;
    grant_due = if_req || dm_req;
    while ((dm_left > 0 || if_left) && cyc < 300) begin
      tick();
      cyc++;
      chk("if_stall", if_stall, if_req && !(exp_a && !win_dm));
      chk("dm_stall", dm_stall, dm_req && !(exp_a && win_dm));
      chk("if_ack", if_ack, exp_a && !win_dm);
      chk("dm_ack", dm_ack, exp_a && win_dm);
      if (exp_a) begin
        chk("mem_req_resp", mem_req, 0);
        if (win_dm) begin
          if (g_we) mem_model[g_addr] = g_wdata;
          else exp_dm_rdata = rd_val;
          dm_left--;
          if (dm_left > 0) begin
            dm_we = 1'($urandom_range(0, 1));
            dm_addr = rnd_addr();
            dm_wdata = {$urandom, $urandom};
          end else begin
            dm_req = 1'b0;
          end
        end else begin
          exp_if_rdata = rd_val;
          if_left = 0;
          if_req = 1'b0;
        end
        if (first_ack < 0) first_ack = cyc;
        last_ack = cyc;
        exp_a = 0;
      end else if (grant_due) begin
        chk("mem_req_grant", mem_req, 1);
        win_dm = dm_req && (!if_req || streak_m != MAXS);
        streak_m = (win_dm && if_req) ? streak_m + 1 : 0;
        g_we = win_dm ? dm_we : 1'b0;
        g_addr = win_dm ? dm_addr : if_addr;
        g_wdata = dm_wdata;
        order_q.push_back(win_dm);
        if (win_dm) n_dm_gr++;
        else n_if_gr++;
        chk("mem_we_grant", mem_we, g_we);
        chk("mem_addr_grant", mem_addr, g_addr);
        if (win_dm && g_we) chk("mem_wdata_grant", mem_wdata, g_wdata);
        in_busy = 1; busy_cnt = 0; grant_due = 0;
        cur_lat = (lat > 0) ? lat : $urandom_range(1, 4);
      end else if (in_busy) begin
        chk("mem_req_busy", mem_req, 1);
        chk("mem_addr_busy", mem_addr, g_addr);
        chk("mem_we_busy", mem_we, g_we);
      end else begin
        chk("mem_req_idle", mem_req, 0);
        grant_due = if_req || dm_req;
      end
      chk("if_rdata", if_rdata, exp_if_rdata);
      chk("dm_rdata", dm_rdata, exp_dm_rdata);
      if (in_busy) begin
        busy_cnt++;
        if (busy_cnt == cur_lat) begin
          rd_val = (win_dm && g_we) ? {$urandom, $urandom} : mval(g_addr);
          mem_ready = 1'b1;
          mem_rdata = rd_val;
          exp_a = 1;
          in_busy = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = {$urandom, $urandom};
        end
      end else begin
        // Stray ready pulses outside an access must be ignored.
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = {$urandom, $urandom};
      end
    end
    if (dm_left > 0 || if_left) chk("round_timeout", 1, 0);
    mem_ready = 1'b0;
    tick();
    chk("end_mem_req", mem_req, 0);
    chk("end_if_ack", if_ack, 0);
    chk("end_dm_ack", dm_ack, 0);
  endtask

  initial begin
    int fa, la, nd;
    bit di;
    bit exp_starve[6];
    exp_starve = '{1, 1, 1, 1, 0, 1};
    apply_reset();
    chk_all_zero("reset");

    // Single fetch: 0x40 -> 0xDEAD, ready in first BUSY cycle.
    mem_model[64'h40] = 64'hDEAD;
    order_q.delete();
    run_round(0, 1, 64'h40, 0, 0, 0, 1, fa, la);
    chk("fetch_latency", fa, 2);
    chk("fetch_rdata", if_rdata, 64'hDEAD);
    chk("fetch_order_len", order_q.size(), 1);

    // Reset mid-BUSY: access abandoned asynchronously, no ack afterwards.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h200; dm_wdata = '0; mem_ready = 1'b0;
    tick();
    chk("abort_mem_req_b1", mem_req, 1);
    tick();
    chk("abort_mem_req_b2", mem_req, 1);
    #2;
    reset = 1'b1;
    dm_req = 1'b0;
    #1;
    chk_all_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_dm_ack", dm_ack, 0);
      chk("abort_no_mem_req", mem_req, 0);
    end

    // DM write 0x100 <= 0x1234, ready on the 3rd BUSY cycle.
    run_round(1, 0, 0, 1, 64'h100, 64'h1234, 3, fa, la);
    chk("write_latency", fa, 4);
    chk("write_dm_rdata_kept", dm_rdata, 0);

    // Simultaneous IF and DM: DM first, IF right after RESP + IDLE.
    order_q.delete();
    run_round(1, 1, 64'h80, 0, 64'h100, 0, 1, fa, la);
    chk("conflict_first_dm", order_q[0], 1);
    chk("conflict_then_if", order_q[1], 0);
    chk("conflict_dm_ack_cyc", fa, 2);
    chk("conflict_if_ack_cyc", la, 5);
    chk("conflict_dm_rdata", dm_rdata, 64'h1234);

    // Starvation: IF held while DM is re-raised after every ack.
    apply_reset();
    order_q.delete();
    run_round(5, 1, 64'h18, 0, 64'h20, 0, 1, fa, la);
    chk("starve_len", order_q.size(), 6);
    for (int i = 0; i < 6; i++) chk($sformatf("starve_order%0d", i), order_q[i], exp_starve[i]);
    chk("starve_last_ack", la, 17);
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if_starve", perf_if_grants, 1);
    chk("perf_dm_starve", perf_dm_grants, 5);
    chk("perf_conf_starve", perf_conflict_cycles, n_conf);
`endif
    order_q.delete();
    run_round(1, 1, 64'h28, 0, 64'h30, 0, 1, fa, la);
    chk("streak_restart_dm_first", order_q[0], 1);

    // Randomized rounds against the transaction model.
    for (int r = 0; r < 30; r++) begin
      nd = $urandom_range(0, 6);
      di = 1'($urandom_range(0, 1));
      if (nd == 0) di = 1;
      run_round(nd, di, rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(),
                {$urandom, $urandom}, 0, fa, la);
    end
`ifdef MEM_ARB_PERF_CNT_EN
    chk("perf_if_final", perf_if_grants, n_if_gr);
    chk("perf_dm_final", perf_dm_grants, n_dm_gr);
    chk("perf_conf_final", perf_conflict_cycles, n_conf);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
